// File: rtl/pipelined_adder_nbit_pkg.sv
// ============================================================================
// pipelined_adder_nbit_pkg : mode encoding and default sizing for the adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipelined_adder_nbit_pkg;

  localparam logic c_mode_add = 1'b0;
  localparam logic c_mode_sub = 1'b1;

  localparam int c_default_width = 64;
  localparam int c_default_chunk = 16;

endpackage

`default_nettype wire

// File: rtl/adder_chunk_stage.sv
// ============================================================================
// adder_chunk_stage : one CHUNK-bit add slice with registered sum/carry/valid
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_chunk_stage
  import pipelined_adder_nbit_pkg::*;
#(
  parameter int CHUNK = c_default_chunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [CHUNK-1:0] w_b_eff;
  logic [CHUNK:0]   w_full;
  logic             w_c_into_msb;

  assign w_b_eff = (i_sub == c_mode_sub) ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, i_cin};

  // Recover the carry into the top bit from the sum bit and its operands
  assign w_c_into_msb = i_a[CHUNK-1] ^ w_b_eff[CHUNK-1] ^ w_full[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_sum   <= w_full[CHUNK-1:0];
      o_cout  <= w_full[CHUNK];
      o_ovf   <= w_c_into_msb ^ w_full[CHUNK];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
// ============================================================================
// pipelined_adder_nbit : skewed, chunk-per-stage pipelined adder/subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_nbit
  import pipelined_adder_nbit_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CHUNK = c_default_chunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_adder_nbit: WIDTH must be a positive multiple of CHUNK");
  end

  logic                  w_adv;
  logic [NUM_CHUNKS-1:0] w_valid;
  logic [NUM_CHUNKS-1:0] w_cout;
  logic [NUM_CHUNKS-1:0] w_ovf;
  logic [CHUNK-1:0]      w_sum     [NUM_CHUNKS];
  logic [CHUNK-1:0]      w_aligned [NUM_CHUNKS];

  // The whole pipeline moves as one; a stalled output freezes every register
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_lane
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic             w_sub;
    logic             w_cin;
    logic             w_vin;

    if (k == 0) begin : g_head
      assign w_a   = in_a[CHUNK-1:0];
      assign w_b   = in_b[CHUNK-1:0];
      assign w_sub = in_sub;
      assign w_cin = in_cin;
      assign w_vin = in_valid;
    end else begin : g_skew
      logic [CHUNK-1:0] r_a [k];
      logic [CHUNK-1:0] r_b [k];
      logic [k-1:0]     r_sub;

      // Operand chunk k waits k cycles so it meets the carry of its own beat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
          end
          r_sub <= '0;
        end else if (w_adv) begin
          r_a[0]   <= in_a[k*CHUNK +: CHUNK];
          r_b[0]   <= in_b[k*CHUNK +: CHUNK];
          r_sub[0] <= in_sub;
          for (int i = 1; i < k; i++) begin
            r_a[i]   <= r_a[i-1];
            r_b[i]   <= r_b[i-1];
            r_sub[i] <= r_sub[i-1];
          end
        end
      end

      assign w_a   = r_a[k-1];
      assign w_b   = r_b[k-1];
      assign w_sub = r_sub[k-1];
      assign w_cin = w_cout[k-1];
      assign w_vin = w_valid[k-1];
    end

    adder_chunk_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_vin),
      .i_a     (w_a),
      .i_b     (w_b),
      .i_sub   (w_sub),
      .i_cin   (w_cin),
      .o_valid (w_valid[k]),
      .o_sum   (w_sum[k]),
      .o_cout  (w_cout[k]),
      .o_ovf   (w_ovf[k])
    );

    if (k == NUM_CHUNKS - 1) begin : g_tail
      assign w_aligned[k] = w_sum[k];
    end else begin : g_deskew
      localparam int DEPTH = NUM_CHUNKS - 1 - k;
      logic [CHUNK-1:0] r_d [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= '0;
          end
        end else if (w_adv) begin
          r_d[0] <= w_sum[k];
          for (int i = 1; i < DEPTH; i++) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end

      assign w_aligned[k] = r_d[DEPTH-1];
    end
  end

  always_comb begin
    out_sum = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      out_sum[k*CHUNK +: CHUNK] = w_aligned[k];
    end
  end

  assign out_valid = w_valid[NUM_CHUNKS-1];
  assign out_cout  = w_cout[NUM_CHUNKS-1];
  assign out_ovf   = w_ovf[NUM_CHUNKS-1];
  // Gated by valid so the flag reads 0 out of reset and across bubbles
  assign out_zero  = out_valid && (out_sum == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
// ============================================================================
// tb_pipelined_adder_nbit : directed vectors against a plain arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder_nbit;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int LAT   = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0]  in_a, in_b;
  logic              out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [WIDTH-1:0]  out_sum;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pops   = 0;
  bit lat_check = 1'b0;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    res_t        r;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];

  pipelined_adder_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] bb;
    logic [64:0] full;
    res_t        r;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = (a[63] == bb[63]) && (r.sum[63] != a[63]);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle with a visible result is checked against the model queue
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got out_valid=1 sum %h expected no result", out_sum);
        end else begin
          chk("sum",  out_sum, q[0].r.sum);
          chk("cout", {63'd0, out_cout}, {63'd0, q[0].r.cout});
          chk("ovf",  {63'd0, out_ovf},  {63'd0, q[0].r.ovf});
          chk("zero", {63'd0, out_zero}, {63'd0, q[0].r.zero});
          if (lat_check)
            chk("latency", 64'(cyc - int'(q[0].acc)), 64'(LAT));
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.r   = model(in_a, in_b, in_cin, in_sub);
        e.acc = 32'(cyc);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub);
    int   n;
    logic ok;
    n = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", q.size());
    end
  endtask

  // Presents one beat and checks out_valid is low until exactly LAT cycles later;
  // returns at the negedge of the result cycle
  task automatic single_latency(input string name, input logic [63:0] a,
                                input logic [63:0] b, input logic cin, input logic sub);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk(name, {63'd0, out_valid}, {63'd0, (i == LAT)});
      if (i < LAT) begin
        step();
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   p0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum",   out_sum, 64'd0);
    chk("rst_flags",     {61'd0, out_cout, out_ovf, out_zero}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    step();

    // Hand-computed pins on the model itself
    r = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("pin_ripple", {r.sum[60:0], r.cout, r.ovf, r.zero}, {61'd0, 3'b101});
    r = model(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    chk("pin_chunk_carry", r.sum, 64'h0000_0000_0001_0000);
    r = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("pin_add_ovf", {r.sum[63], r.cout, r.ovf}, 64'b101);
    r = model(64'd5, 64'd7, 1'b1, 1'b1);
    chk("pin_sub_neg", {r.sum[62:0], r.cout}, {63'h7FFF_FFFF_FFFF_FFFE, 1'b0});
    r = model(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    chk("pin_sub_ovf", r.sum, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("pin_sub_ovf_flags", {62'd0, r.cout, r.ovf}, 64'b11);

    lat_check = 1'b1;

    // Full ripple through all four chunks
    single_latency("t1_valid_timing", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("t1_sum",  out_sum, 64'd0);
    chk("t1_cout", {63'd0, out_cout}, 64'd1);
    chk("t1_zero", {63'd0, out_zero}, 64'd1);
    chk("t1_ovf",  {63'd0, out_ovf},  64'd0);
    step();

    // Cross-chunk carry, signed overflow, subtraction
    send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'd5, 64'd7, 1'b1, 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    drain();

    // Back-to-back throughput
    p0 = pops;
    for (int i = 1; i <= 8; i++)
      send(64'(i), 64'h0000_0001_0001_0001 * 64'(i), 1'b0, 1'b0);
    drain();
    chk("t4_result_count", 64'(pops - p0), 64'd8);

    // Backpressure: hold out_ready low for 5 cycles once results appear
    lat_check = 1'b0;
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(64'h1000 + 64'(i), 64'hFFFF_0000_0000_0003 * 64'(i), 1'(i % 2), 1'(i % 2));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 100);
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("t5_in_ready_stalled", {63'd0, in_ready}, 64'd0);
          chk("t5_valid_held",       {63'd0, out_valid}, 64'd1);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_result_count", 64'(pops - p0), 64'd6);

    // Reset with beats in flight
    lat_check = 1'b1;
    send(64'd11, 64'd22, 1'b0, 1'b0);
    send(64'd33, 64'd44, 1'b0, 1'b0);
    send(64'd55, 64'd66, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk("t6_valid_before_rst", {63'd0, out_valid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_drop", {63'd0, out_valid}, 64'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_stale_result", {63'd0, out_valid}, 64'd0);
      step();
    end
    single_latency("t6_new_beat_timing", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
                   1'b1, 1'b0);
    chk("t6_new_sum", out_sum, 64'h1234_5678_9ABC_DF01);
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
